// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and sizing helpers for sram_ctrl_param and its wait counter.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_DQ_W      = 16;
  localparam int unsigned DEF_ADDR_W    = 18;
  // Wait-state counter width; covers WAIT_CYCLES 0..15.
  localparam int unsigned WAIT_W        = 4;

  // Number of SRAM beats needed for one CPU word.
  function automatic int unsigned beats(input int unsigned data_w, input int unsigned dq_w);
    return data_w / dq_w;
  endfunction

  // Ceiling log2; log2c(1) = 0.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-beat wait-state counter: holds each beat for WAIT_CYCLES+1 cycles while
// run is high, flags the last cycle of a beat and steps the beat index.
// Counters return to zero whenever run is low.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BEATS       = 2,
  parameter int unsigned BEAT_W      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [BEAT_W-1:0] beat,
  output logic              last,
  output logic              final_beat
);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // Last-cycle flags and next counter values.
  always_comb begin
    last       = (wait_q == WAIT_W'(WAIT_CYCLES));
    final_beat = last && (beat_q == BEAT_W'(BEATS - 1));
    wait_d     = '0;
    beat_d     = '0;
    if (run) begin
      if (last) begin
        wait_d = '0;
        beat_d = beat_q + 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
        beat_d = beat_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/sram_ctrl_param.sv
// Parametrised SRAM controller: splits one DATA_W load/store into narrow SRAM
// beats with configurable wait states and stalls the pipeline through ready.
// SRAM pins are decoded from registered state only.
// Optional build macro: SRAM_POSTED_WRITE_EN (stores complete in one CPU cycle).
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SRAM_DQ_W   = DEF_DQ_W,
  parameter int unsigned SRAM_ADDR_W = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            ALU_Res,
  input  logic [DATA_W-1:0]      writeData,
  output logic [DATA_W-1:0]      readData,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int unsigned BEATS   = beats(DATA_W, SRAM_DQ_W);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? log2c(BEATS) : 1;
  localparam int unsigned BYTE_SH = log2c(DATA_W / 8);
`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [31:0]            off;
  logic [BEAT_W-1:0]      beat;
  logic                   last, final_beat, run, we_act;
  logic [SRAM_DQ_W-1:0]   dq_out;

  assign run = (state_q == ACCESS);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEATS       (BEATS),
    .BEAT_W      (BEAT_W)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .beat       (beat),
    .last       (last),
    .final_beat (final_beat)
  );

  // Next-state: latch the request in IDLE, collect read slices, sequence beats.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    off     = ALU_Res - 32'(BASE_ADDR);
    unique case (state_q)
      IDLE: begin
        if (wr_en | rd_en) begin
          state_d = ACCESS;
          op_wr_d = wr_en;
          base_d  = SRAM_ADDR_W'((off >> BYTE_SH) * BEATS);
          wdata_d = writeData;
        end
      end
      ACCESS: begin
        if (!op_wr_q && last) rdata_d[beat*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
        // Posted writes have already released the pipeline, so they skip DONE.
        if (final_beat) state_d = (POSTED && op_wr_q) ? IDLE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Pipeline handshake.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = POSTED ? ~rd_en : ~(wr_en | rd_en);
      ACCESS:  ready = POSTED && op_wr_q && !(wr_en | rd_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // SRAM pin decode; WE rises on the last beat cycle for address/data hold.
  always_comb begin
    we_act    = (state_q == ACCESS) && op_wr_q;
    SRAM_ADDR = base_q + SRAM_ADDR_W'(beat);
    SRAM_WE_N = ~(we_act && ((WAIT_CYCLES == 0) || !last));
    dq_out    = wdata_q[beat*SRAM_DQ_W +: SRAM_DQ_W];
  end

  assign SRAM_DQ   = we_act ? dq_out : 'z;
  assign readData  = rdata_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
